// File: rtl/mux_n_reg.sv
// ---------------------------------------------------------------------------
// mux_n_reg -- CH-way registered multiplexer with valid/ready handshake.
//
// Selects one WIDTH-bit channel out of a flat input bus and registers it,
// together with the index of the channel that produced it. Channel choice is
// either direct (mode=0, from sel) or round-robin scan (mode=1, from an
// internal pointer that advances on every accepted transfer).
//
// Parameters:
//   WIDTH  data width per channel (>= 1)
//   CH     channel count (2..16, need not be a power of 2)
//   SEL_W  ceil(log2(CH)), derived, not overridable
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   din        flat input bus, channel k at [k*WIDTH +: WIDTH]
//   sel        direct channel select (mode=0 only)
//   mode       0 = direct select, 1 = round-robin scan
//   in_valid   upstream data valid
//   in_ready   block accepts data this cycle
//   dout       registered selected data
//   dout_ch    registered index of the channel behind dout
//   out_valid  dout/dout_ch hold an untaken result
//   out_ready  downstream takes the result
//   sel_err    sticky out-of-range select flag (only with the macro below)
//
// Build option:
//   MUX_N_REG_SEL_CHECK_EN  adds sel_err and the select-range check.
// ---------------------------------------------------------------------------
module mux_n_reg #(
    parameter  int WIDTH = 8,
    parameter  int CH    = 4,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   din,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      dout,
    output logic [SEL_W-1:0]      dout_ch,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUX_N_REG_SEL_CHECK_EN
   ,output logic                  sel_err
`endif
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_next;
    logic [SEL_W-1:0] eff_ch;
    logic [WIDTH-1:0] sel_data;
    logic             accept;

    // Output register is free when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign eff_ch   = mode ? rr_ptr : sel;
    assign rr_next  = (rr_ptr == SEL_W'(CH - 1)) ? '0 : rr_ptr + 1'b1;

    // Indices at or above CH (only reachable when CH is not a power of 2)
    // match no channel and fall through to the zero default.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (eff_ch == SEL_W'(k)) begin
                sel_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            dout_ch   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                dout      <= sel_data;
                dout_ch   <= eff_ch;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Pointer parks at 0 in direct mode so each scan starts at channel 0.
            if (!mode) begin
                rr_ptr <= '0;
            end else if (accept) begin
                rr_ptr <= rr_next;
            end
        end
    end

`ifdef MUX_N_REG_SEL_CHECK_EN
    logic sel_oor;

    // Extra bit so the compare against CH never truncates CH.
    assign sel_oor = ({1'b0, sel} >= (SEL_W+1)'(CH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (accept && !mode && sel_oor) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule
